// File: rtl/sparc_ifu_starv_mon.sv
// IFU thread-select starvation monitor: per-thread saturating wait counters,
// threshold compare, round-robin pick of one starving thread, sticky history.
module sparc_ifu_starv_mon #(
    parameter int NTHR = 4,
    parameter int CW   = 5,
    parameter int PW   = 2
) (
    input  logic            clk,
    input  logic            arst_l,
    input  logic            se,
    input  logic            si,
    output logic            so,
    input  logic            mon_en,
    input  logic [CW-1:0]   limit_val,
    input  logic [NTHR-1:0] thr_ready,
    input  logic [NTHR-1:0] thr_grant,
    input  logic            hist_clr,
    output logic [NTHR-1:0] starv,
    output logic            starv_any,
    output logic [NTHR-1:0] starv_sel,
    output logic [NTHR-1:0] starv_hist
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0]   cnt_q [NTHR];
    logic [CW-1:0]   cnt_d [NTHR];
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NTHR-1:0] starv_hist_q, starv_hist_d;
    logic [PW-1:0]   sel_idx;
    logic            sel_found;
    logic            unused_scan;

    // Scan chain is stitched in after synthesis; the RTL only ties it off.
    assign so          = 1'b0;
    assign unused_scan = &{1'b0, se, si};

    // Disable, grant and not-ready all clear the counter, so a single
    // "keep counting" condition captures the whole priority chain.
    always_comb begin
        for (int t = 0; t < NTHR; t++) begin
            // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
            cnt_d[t] = '0;
            if (mon_en && !thr_grant[t] && thr_ready[t]) begin
                cnt_d[t] = (cnt_q[t] == CNT_MAX) ? cnt_q[t] : cnt_q[t] + 1'b1;
            end
        end
    end

    always_comb begin
        for (int t = 0; t < NTHR; t++) begin
            starv[t] = (limit_val != '0) && (cnt_q[t] >= limit_val);
        end
    end

    assign starv_any = |starv;

    always_comb begin
        int idx;
        idx       = 0;
        starv_sel = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int off = 0; off < NTHR; off++) begin
            idx = (int'(rr_ptr_q) + off) % NTHR;
            if (!sel_found && starv[PW'(idx)]) begin
                sel_found             = 1'b1;
                sel_idx               = PW'(idx);
                starv_sel[PW'(idx)]   = 1'b1;
            end
        end
    end

    // The pointer only moves when the forced-priority pick is actually served.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if ((starv_sel & thr_grant) != '0) begin
            rr_ptr_d = PW'((int'(sel_idx) + 1) % NTHR);
        end
    end

    assign starv_hist_d = (~{NTHR{hist_clr}} & starv_hist_q) | starv;
    assign starv_hist   = starv_hist_q;

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            // NOTE: the counter array is small and drives outputs directly, so it is reset like any flop.
            for (int t = 0; t < NTHR; t++) begin
                cnt_q[t] <= '0;
            end
            rr_ptr_q     <= '0;
            starv_hist_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
            for (int t = 0; t < NTHR; t++) begin
                cnt_q[t] <= cnt_d[t];
            end
            rr_ptr_q     <= rr_ptr_d;
            starv_hist_q <= starv_hist_d;
        end
    end

endmodule

// File: tb/tb_sparc_ifu_starv_mon.sv
// Scoreboard bench for sparc_ifu_starv_mon: the driver pushes expected outputs
// from a behavioural model, a negedge monitor pops and compares them.
module tb_sparc_ifu_starv_mon;

    localparam int N    = 4;
    localparam int CW   = 5;
    localparam int PW   = 2;
    localparam int SATV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          arst_l;
    logic          se, si, so;
    logic          mon_en;
    logic [CW-1:0] limit_val;
    logic [N-1:0]  thr_ready, thr_grant;
    logic          hist_clr;
    logic [N-1:0]  starv, starv_sel, starv_hist;
    logic          starv_any;

    sparc_ifu_starv_mon #(.NTHR(N), .CW(CW), .PW(PW)) dut (
        .clk        (clk),
        .arst_l     (arst_l),
        .se         (se),
        .si         (si),
        .so         (so),
        .mon_en     (mon_en),
        .limit_val  (limit_val),
        .thr_ready  (thr_ready),
        .thr_grant  (thr_grant),
        .hist_clr   (hist_clr),
        .starv      (starv),
        .starv_any  (starv_any),
        .starv_sel  (starv_sel),
        .starv_hist (starv_hist)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] starv;
        logic [N-1:0] sel;
        logic [N-1:0] hist;
        logic         any;
        logic         so;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   cyc_no = 0;

    // Behavioural model: wait lengths in cycles, the thread the next scan
    // starts at, and the set of threads seen starving since the last clear.
    int           m_wait [N];
    int           m_next;
    logic [N-1:0] m_hist;

    task automatic check(input string name, input int cyc, input logic [N-1:0] got, input logic [N-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, got, want);
        end
    endtask

    function automatic logic [N-1:0] model_starv(input logic [CW-1:0] lim);
        logic [N-1:0] s;
        s = '0;
        for (int t = 0; t < N; t++) s[t] = (lim != 0) && (m_wait[t] >= int'(lim));
        return s;
    endfunction

    function automatic int model_pick(input logic [N-1:0] s);
        for (int off = 0; off < N; off++)
            if (s[(m_next + off) % N]) return (m_next + off) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] model_sel(input logic [CW-1:0] lim);
        int p;
        logic [N-1:0] v;
        v = '0;
        p = model_pick(model_starv(lim));
        if (p >= 0) v[p] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int t = 0; t < N; t++) m_wait[t] = 0;
        m_next = 0;
        m_hist = '0;
    endtask

    task automatic push_exp(input logic [CW-1:0] lim);
        exp_t e;
        e.starv = model_starv(lim);
        e.sel   = model_sel(lim);
        e.hist  = m_hist;
        e.any   = (e.starv != 0);
        e.so    = 1'b0;
        e.cyc   = cyc_no;
        exp_q.push_back(e);
    endtask

    // One functional cycle: called just after a rising edge.
    task automatic cyc(input logic [N-1:0] rdy, input logic [N-1:0] gnt,
                       input logic [CW-1:0] lim, input logic en, input logic hclr);
        logic [N-1:0] s;
        int           p;
        thr_ready = rdy;
        thr_grant = gnt;
        limit_val = lim;
        mon_en    = en;
        hist_clr  = hclr;
        se        = 1'($urandom);
        si        = 1'($urandom);
        push_exp(lim);
        s = model_starv(lim);
        p = model_pick(s);
        @(posedge clk);
        for (int t = 0; t < N; t++) begin
            if (!en || gnt[t] || !rdy[t]) m_wait[t] = 0;
            else if (m_wait[t] < SATV)    m_wait[t] = m_wait[t] + 1;
        end
        if (p >= 0 && gnt[p]) m_next = (p + 1) % N;
        m_hist = (hclr ? '0 : m_hist) | s;
        cyc_no++;
        #1;
    endtask

    // Reset asserted mid-cycle; outputs are checked before any clock edge.
    task automatic reset_pulse();
        #1;
        arst_l = 1'b0;
        model_reset();
        push_exp(limit_val);
        @(posedge clk);
        #1;
        arst_l = 1'b1;
        cyc_no++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("starv",      e.cyc, starv,      e.starv);
                check("starv_sel",  e.cyc, starv_sel,  e.sel);
                check("starv_hist", e.cyc, starv_hist, e.hist);
                check("starv_any",  e.cyc, N'(starv_any), N'(e.any));
                check("so",         e.cyc, N'(so),        N'(e.so));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [N-1:0] rdy, gnt;
        logic [CW-1:0] lim;
        logic en, hclr;
        int r;

        arst_l = 1'b0; se = 1'b0; si = 1'b0; mon_en = 1'b0; limit_val = '0;
        thr_ready = '0; thr_grant = '0; hist_clr = 1'b0;
        model_reset();
        push_exp('0);
        @(posedge clk);
        @(posedge clk);
        #1;
        arst_l = 1'b1;

        // Thread 1 starves at limit 24, is granted at cycle 30, then history is cleared.
        for (int c = 0; c < 30; c++) cyc(4'b0010, 4'b0000, 5'd24, 1'b1, 1'b0);
        cyc(4'b0010, 4'b0010, 5'd24, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) cyc(4'b0010, 4'b0000, 5'd24, 1'b1, 1'b0);
        cyc(4'b0000, 4'b0000, 5'd24, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) cyc(4'b0000, 4'b0000, 5'd24, 1'b1, 1'b0);

        // Saturation at 31 with the limit at the saturation value.
        for (int c = 0; c < 40; c++) cyc(4'b0010, 4'b0000, 5'd31, 1'b1, 1'b0);

        // Round-robin over threads 0, 2, 3 from a fresh pointer.
        reset_pulse();
        for (int c = 0; c < 6; c++) cyc(4'b1101, 4'b0000, 5'd5, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(4'b1101, model_sel(5'd5), 5'd5, 1'b1, 1'b0);
            cyc(4'b1101, 4'b0000, 5'd5, 1'b1, 1'b0);
        end

        // Limit 0 disables flags; raising it takes effect in the same cycle.
        for (int c = 0; c < 40; c++) cyc(4'b1111, 4'b0000, 5'd0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++)  cyc(4'b1111, 4'b0000, 5'd10, 1'b1, 1'b0);

        // Monitor disable at count 20, then a mid-cycle reset.
        reset_pulse();
        for (int c = 0; c < 20; c++) cyc(4'b0001, 4'b0000, 5'd18, 1'b1, 1'b0);
        cyc(4'b0001, 4'b0000, 5'd18, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) cyc(4'b0001, 4'b0000, 5'd18, 1'b1, 1'b0);
        reset_pulse();

        // hist_clr in the same cycle starv[2] first rises: set wins.
        for (int c = 0; c < 3; c++) cyc(4'b0100, 4'b0000, 5'd3, 1'b1, 1'b0);
        cyc(4'b0100, 4'b0000, 5'd3, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) cyc(4'b0100, 4'b0000, 5'd3, 1'b1, 1'b0);

        // Randomised traffic with sticky ready lines so starvation occurs.
        rdy = '0; lim = 5'd6;
        for (int c = 0; c < 2000; c++) begin
            for (int t = 0; t < N; t++) if ($urandom_range(0, 7) == 0) rdy[t] = ~rdy[t];
            if ($urandom_range(0, 19) == 0)
                lim = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 12));
            r = $urandom_range(0, 9);
            if (r < 4)       gnt = '0;
            else if (r < 7)  gnt = model_sel(lim);
            else if (r < 9)  gnt = N'(1 << $urandom_range(0, N - 1));
            else             gnt = N'($urandom);
            en   = ($urandom_range(0, 49) != 0);
            hclr = ($urandom_range(0, 19) == 0);
            cyc(rdy, gnt, lim, en, hclr);
            if (c == 1000) reset_pulse();
        end

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sparc_ifu_starv_mon.md
# sparc_ifu_starv_mon

Parametrised multi-thread starvation monitor for the IFU thread-select path. Each of NTHR threads has a saturating wait counter that counts cycles spent ready but not granted. A thread is flagged starving when its count reaches a programmable limit. A round-robin picker selects one starving thread for forced priority, and sticky history bits record starvation events for debug readout.

## Interface
Parameters:
- NTHR, 4, number of threads monitored (2..8)
- CW, 5, counter width; saturation value 2^CW-1
- PW, 2, round-robin pointer width; must satisfy 2^PW >= NTHR

Ports:
- clk  in  1  core clock
- arst_l  in  1  asynchronous, active-low reset
- se  in  1  scan enable; no functional effect in RTL
- si  in  1  scan in; no functional effect in RTL
- so  out  1  scan out; driven 0 in RTL
- mon_en  in  1  monitor enable; 0 synchronously clears all counters
- limit_val  in  CW  starvation threshold; 0 disables all starv flags
- thr_ready  in  NTHR  thread t is ready to issue this cycle
- thr_grant  in  NTHR  thread t was selected this cycle (one-hot or zero expected)
- hist_clr  in  1  synchronous clear of starv_hist
- starv  out  NTHR  thread t count >= limit_val (combinational from registered count)
- starv_any  out  1  OR of starv
- starv_sel  out  NTHR  one-hot round-robin pick among starving threads; 0 if none
- starv_hist  out  NTHR  sticky record of starv since last hist_clr

## Operation
- Per-thread counter cnt[t] (CW bits) next-state, by priority:
  - mon_en=0: 0.
  - thr_grant[t]=1: 0. This holds even if thr_ready[t]=0.
  - thr_ready[t]=0: 0.
  - Otherwise: cnt+1, saturating at 2^CW-1 with no wrap.
- starv[t] = (limit_val != 0) & (cnt[t] >= limit_val). The compare is unsigned on full CW bits and uses the current limit_val, so a limit change takes effect in the same cycle.
- starv_sel: scan threads cyclically starting at index rr_ptr and pick the first t with starv[t]=1. Only one bit may be set.
- rr_ptr (PW bits):
  - Updates only when the selected thread is granted, i.e. (starv_sel & thr_grant) != 0. It then takes the value (selected index + 1) mod NTHR.
  - Otherwise it holds.
- starv_hist[t] next = ~hist_clr & starv_hist[t] | starv[t]. When set and clear coincide, set wins.
- Multi-hot thr_grant: each bit is applied to its own counter independently. rr_ptr advances only on the starv_sel match.

## Timing
- Reset (arst_l=0, asynchronous):
  - cnt=0, rr_ptr=0, starv_hist=0.
  - Therefore starv=0, starv_any=0, starv_sel=0, and so=0 immediately.
  - Deassertion is sampled on the next clk rising edge.
- A thread held ready and ungranted from edge 0 has cnt=k after edge k. With limit L, starv rises in the cycle after edge L, i.e. latency L cycles.
- A grant clears cnt at the following edge. starv drops in the cycle after the grant edge.
- starv, starv_any and starv_sel are combinational from flops plus limit_val. They have no input-to-output path from thr_ready, thr_grant or mon_en.
- starv_hist lags starv by one edge.
- Asserting reset mid-count discards all state. No partial results are retained.
- Saturation: with CW=5, cnt holds at 31. With limit_val=31, starv stays asserted for as long as the thread is starved.

## Test plan
- NTHR=4, CW=5, limit_val=24; thread 1 ready and never granted. Expect starv=4'b0010 from cycle 24 onward; cnt[1] saturates at 31; starv_hist[1]=1 one edge after starv.
- Same setup, then grant thread 1 at cycle 30. Expect cnt[1]=0 after that edge; starv[1]=0 next cycle; starv_hist[1] stays 1 until hist_clr pulses, then reads 0.
- Threads 0, 2 and 3 all starving with rr_ptr=0. Expect starv_sel=0001. Grant thread 0: expect 0100. Grant thread 2: expect 1000. Grant thread 3: rr_ptr wraps to 0.
- limit_val=0 with all threads starved for 40 cycles: expect starv=0 throughout. Then switch limit_val to 10: expect starv=1111 in the same cycle.
- mon_en drops for one cycle while cnt=20: expect cnt=0 after the edge. Pulse arst_l low mid-cycle: expect all outputs 0 immediately, without a clock edge.
- hist_clr asserted in the same cycle starv[2] first rises: expect starv_hist[2]=1 after the edge (set wins).
